// File: rtl/f3_stim_seq_if.sv
// Handshake and stimulus bundle between f3_stim_seq and its user/function under test.
// master: the sequencer side; slave: the controller / function-under-test side.
interface f3_stim_seq_if;
    logic       start;
    logic       r_in;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] fail_idx;

    modport master (
        input  start, r_in,
        output x, y, busy, done, pass, err_cnt, fail_idx
    );

    modport slave (
        output start, r_in,
        input  x, y, busy, done, pass, err_cnt, fail_idx
    );
endinterface

// File: rtl/f3_stim_seq.sv
// Clocked truth-table sweeper and checker for r = x & ~y.
// Optional macro F3_SEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module f3_stim_seq #(
    parameter int HOLD = 1
) (
    input  logic          clk,
    input  logic          reset,
    f3_stim_seq_if.master bus
);

    localparam logic [3:0] HOLD_V = 4'(HOLD);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t     state;
    logic [1:0] idx;
    logic [3:0] hcnt;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_r;
    logic [1:0] fidx_r;

    logic       exp_r;
    logic       mism;
    logic [2:0] err_next;
    logic       stop;

    always_comb begin
        exp_r    = idx[1] & ~idx[0];
        mism     = (bus.r_in != exp_r);
        err_next = err_r;
        if (mism && (err_r != 3'd4))
            err_next = err_r + 3'd1;
`ifdef F3_SEQ_STOP_ON_FAIL_EN
        stop = (idx == 2'd3) || mism;
`else
        stop = (idx == 2'd3);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            hcnt   <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= 3'd0;
            fidx_r <= 2'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_r  <= 3'd0;
                        fidx_r <= 2'd0;
                        pass_r <= 1'b0;
                        idx    <= 2'd0;
                        hcnt   <= 4'd0;
                        busy_r <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (hcnt != HOLD_V) begin
                        hcnt <= hcnt + 4'd1;
                    end else begin
                        err_r <= err_next;
                        // err_r == 0 means no earlier mismatch in this sweep
                        if (mism && (err_r == 3'd0))
                            fidx_r <= idx;
                        hcnt <= 4'd0;
                        if (stop) begin
                            // pass uses the count including this final compare
                            pass_r <= (err_next == 3'd0);
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            idx    <= 2'd0;
                            state  <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // x/y come straight from the index register, so they are glitch-free
    assign bus.x        = idx[1];
    assign bus.y        = idx[0];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.err_cnt  = err_r;
    assign bus.fail_idx = fidx_r;

endmodule

// File: tb/tb_f3_stim_seq.sv
// Directed bench for f3_stim_seq: one HOLD=0 and one HOLD=2 instance on a shared clock.
module tb_f3_stim_seq;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   mode0;
    int   mode2;

    f3_stim_seq_if a ();
    f3_stim_seq_if b ();

    f3_stim_seq #(.HOLD(0)) dut0 (.clk(clk), .reset(reset), .bus(a));
    f3_stim_seq #(.HOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(b));

`ifdef F3_SEQ_STOP_ON_FAIL_EN
    localparam int NV_S0   = 3;
    localparam int NV_S1   = 1;
    localparam int ERR_S1  = 1;
`else
    localparam int NV_S0   = 4;
    localparam int NV_S1   = 4;
    localparam int ERR_S1  = 3;
`endif

    // mode 0: healthy gate, 1: stuck at 0, 2: stuck at 1
    function automatic logic rmodel(int m, logic xv, logic yv);
        case (m)
            0:       return xv & ~yv;
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign a.r_in = rmodel(mode0, a.x, a.y);
    assign b.r_in = rmodel(mode2, b.x, b.y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; a.start = 1'b1; b.start = 1'b1;
        tick();
        tick();
        tests++;
        if (a.busy !== 1'b0 || b.busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_vs_start: busy a=%b b=%b, want 0 0", a.busy, b.busy);
        end
        reset = 1'b0; a.start = 1'b0; b.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if ({a.x, a.y, a.busy, a.done, a.pass, a.err_cnt, a.fail_idx} !== 10'd0 ||
                {b.x, b.y, b.busy, b.done, b.pass, b.err_cnt, b.fail_idx} !== 10'd0) begin
                failed++;
                $display("FAIL reset_idle%0d: a=%b b=%b, want all zero", c,
                         {a.x, a.y, a.busy, a.done, a.pass, a.err_cnt, a.fail_idx},
                         {b.x, b.y, b.busy, b.done, b.pass, b.err_cnt, b.fail_idx});
            end
        end
    endtask

    task automatic test_sweep_correct();
        mode0 = 0;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({a.x, a.y} !== 2'(k) || a.busy !== 1'b1 || a.done !== 1'b0) begin
                failed++;
                $display("FAIL correct_vec%0d: xy=%b busy=%b done=%b, want xy=%b busy=1 done=0",
                         k, {a.x, a.y}, a.busy, a.done, 2'(k));
            end
            tick();
        end
        tests++;
        if (a.done !== 1'b1 || a.busy !== 1'b0 || a.pass !== 1'b1 || a.err_cnt !== 3'd0) begin
            failed++;
            $display("FAIL correct_done: done=%b busy=%b pass=%b err=%0d, want 1 0 1 0",
                     a.done, a.busy, a.pass, a.err_cnt);
        end
        tick();
        tests++;
        if (a.done !== 1'b0 || a.pass !== 1'b1) begin
            failed++;
            $display("FAIL correct_after: done=%b pass=%b, want 0 1", a.done, a.pass);
        end
    endtask

    task automatic test_stuck0_hold2();
        mode2 = 1;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        for (int k = 0; k < NV_S0; k++) begin
            for (int h = 0; h < 3; h++) begin
                tests++;
                if ({b.x, b.y} !== 2'(k) || b.busy !== 1'b1 || b.done !== 1'b0) begin
                    failed++;
                    $display("FAIL stuck0_vec%0d_h%0d: xy=%b busy=%b done=%b, want xy=%b busy=1 done=0",
                             k, h, {b.x, b.y}, b.busy, b.done, 2'(k));
                end
                tick();
            end
        end
        tests++;
        if (b.done !== 1'b1 || b.pass !== 1'b0 || b.err_cnt !== 3'd1 || b.fail_idx !== 2'd2) begin
            failed++;
            $display("FAIL stuck0_done: done=%b pass=%b err=%0d fidx=%0d, want 1 0 1 2",
                     b.done, b.pass, b.err_cnt, b.fail_idx);
        end
        tick();
    endtask

    task automatic test_stuck1_hold0();
        mode0 = 2;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        for (int k = 0; k < NV_S1; k++) begin
            tests++;
            if ({a.x, a.y} !== 2'(k) || a.done !== 1'b0) begin
                failed++;
                $display("FAIL stuck1_vec%0d: xy=%b done=%b, want xy=%b done=0",
                         k, {a.x, a.y}, a.done, 2'(k));
            end
            tick();
        end
        tests++;
        if (a.done !== 1'b1 || a.pass !== 1'b0 || a.err_cnt !== 3'(ERR_S1) || a.fail_idx !== 2'd0) begin
            failed++;
            $display("FAIL stuck1_done: done=%b pass=%b err=%0d fidx=%0d, want 1 0 %0d 0",
                     a.done, a.pass, a.err_cnt, a.fail_idx, ERR_S1);
        end
        tick();
        tick();
        tests++;
        if (a.busy !== 1'b0 || a.err_cnt !== 3'(ERR_S1) || a.fail_idx !== 2'd0) begin
            failed++;
            $display("FAIL stuck1_hold: busy=%b err=%0d fidx=%0d, want 0 %0d 0",
                     a.busy, a.err_cnt, a.fail_idx, ERR_S1);
        end
    endtask

    task automatic test_restart_ignored();
        mode0 = 0;
        a.start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            a.start = (k < 2);
            tests++;
            if ({a.x, a.y} !== 2'(k) || a.busy !== 1'b1) begin
                failed++;
                $display("FAIL restart_vec%0d: xy=%b busy=%b, want xy=%b busy=1",
                         k, {a.x, a.y}, a.busy, 2'(k));
            end
            tick();
        end
        tests++;
        if (a.done !== 1'b1 || a.pass !== 1'b1 || a.err_cnt !== 3'd0) begin
            failed++;
            $display("FAIL restart_done: done=%b pass=%b err=%0d, want 1 1 0",
                     a.done, a.pass, a.err_cnt);
        end
        tick();
        tick();
        tests++;
        if (a.busy !== 1'b0 || a.done !== 1'b0) begin
            failed++;
            $display("FAIL restart_idle: busy=%b done=%b, want 0 0", a.busy, a.done);
        end
    endtask

    task automatic test_reset_mid();
        mode0 = 2;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({a.x, a.y, a.busy, a.done, a.pass, a.err_cnt, a.fail_idx} !== 10'd0) begin
            failed++;
            $display("FAIL reset_mid: outputs=%b, want all zero",
                     {a.x, a.y, a.busy, a.done, a.pass, a.err_cnt, a.fail_idx});
        end
        mode0 = 0;
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({a.x, a.y} !== 2'(k) || a.busy !== 1'b1) begin
                failed++;
                $display("FAIL reset_fresh_vec%0d: xy=%b busy=%b, want xy=%b busy=1",
                         k, {a.x, a.y}, a.busy, 2'(k));
            end
            tick();
        end
        tests++;
        if (a.done !== 1'b1 || a.pass !== 1'b1 || a.err_cnt !== 3'd0) begin
            failed++;
            $display("FAIL reset_fresh_done: done=%b pass=%b err=%0d, want 1 1 0",
                     a.done, a.pass, a.err_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        mode0 = 2;
        a.start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = (a.done === 1'b1);
        end
        tests++;
        if (!seen || a.err_cnt !== 3'(ERR_S1) || a.pass !== 1'b0) begin
            failed++;
            $display("FAIL b2b_first: seen=%b err=%0d pass=%b, want 1 %0d 0",
                     seen, a.err_cnt, a.pass, ERR_S1);
        end
        mode0 = 0;
        tick();
        tests++;
        if (a.busy !== 1'b0 || a.err_cnt !== 3'(ERR_S1)) begin
            failed++;
            $display("FAIL b2b_idle: busy=%b err=%0d, want 0 %0d", a.busy, a.err_cnt, ERR_S1);
        end
        tick();
        a.start = 1'b0;
        tests++;
        if (a.busy !== 1'b1 || a.err_cnt !== 3'd0 || a.fail_idx !== 2'd0 ||
            a.pass !== 1'b0 || {a.x, a.y} !== 2'b00) begin
            failed++;
            $display("FAIL b2b_restart: busy=%b err=%0d fidx=%0d pass=%b xy=%b, want 1 0 0 0 00",
                     a.busy, a.err_cnt, a.fail_idx, a.pass, {a.x, a.y});
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (a.done === 1'b1);
        end
        tests++;
        if (!seen || a.pass !== 1'b1 || a.err_cnt !== 3'd0) begin
            failed++;
            $display("FAIL b2b_second: seen=%b pass=%b err=%0d, want 1 1 0",
                     seen, a.pass, a.err_cnt);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        failed = 0;
        mode0 = 0;
        mode2 = 0;
        test_reset();
        test_sweep_correct();
        test_stuck0_hold2();
        test_stuck1_hold0();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
